edge_event_unit: RTL and testbench

//  Multi-channel edge event unit for asynchronous board inputs (buttons, switches, UART/GPIO lines).
//  Per channel: synchronise, detect edges per a runtime mode, emit a 1-cycle pulse, latch a sticky

---
 rtl/edge_event_unit_pkg.sv | 9 +
 rtl/edge_event_unit_chan.sv | 79 +++++++
 rtl/edge_event_unit.sv | 95 +++++++++
 tb/tb_edge_event_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/edge_event_unit_pkg.sv
// Shared definitions for the edge event unit: edge-mode encodings (also used by the MMIO decoder).
package edge_event_unit_pkg;

    localparam logic [1:0] EDGE_OFF  = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

endpackage

// File: rtl/edge_event_unit_chan.sv
// One edge event channel: synchroniser, edge detect, pulse flop, sticky pending flag and
// saturating event counter.
module edge_event_chan
    import edge_event_unit_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 signal_i,
    input  logic [1:0]           mode_i,
    input  logic                 primed_i,
    input  logic                 pend_clr_i,
    input  logic                 cnt_clr_i,
    output logic                 edge_pulse_o,
    output logic                 pending_o,
    output logic [CNT_WIDTH-1:0] cnt_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q;
    logic                   pulse_q, pulse_d;
    logic                   pend_q, pend_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   rise, fall, ev;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], signal_i};
        rise   = sync_q[SYNC_STAGES-1] & ~hist_q;
        fall   = ~sync_q[SYNC_STAGES-1] & hist_q;

        ev = 1'b0;
        case (mode_i)
            EDGE_OFF:  ev = 1'b0;
            EDGE_RISE: ev = rise;
            EDGE_FALL: ev = fall;
            EDGE_BOTH: ev = rise | fall;
            default:   ev = 1'b0;
        endcase
        ev = ev & primed_i;

        pulse_d = ev;
        // A new event outranks a same-cycle clear so it is never lost.
        pend_d  = ev ? 1'b1 : (pend_clr_i ? 1'b0 : pend_q);

        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = ev ? CNT_WIDTH'(1) : '0;
        end else if (ev) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            hist_q  <= 1'b0;
            pulse_q <= 1'b0;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            hist_q  <= sync_q[SYNC_STAGES-1];
            pulse_q <= pulse_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    assign edge_pulse_o = pulse_q;
    assign pending_o    = pend_q;
    assign cnt_o        = cnt_q;

endmodule

// File: rtl/edge_event_unit.sv
// Multi-channel edge event unit: per-channel detectors plus post-reset priming, IRQ reduction,
// lowest-index pending encoder and counter readback mux.
module edge_event_unit
    import edge_event_unit_pkg::*;
#(
    parameter  int WIDTH       = 1,
    parameter  int SYNC_STAGES = 2,
    parameter  int CNT_WIDTH   = 8,
    localparam int IDX_W       = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     signal_in,
    input  logic [2*WIDTH-1:0]   mode,
    input  logic [WIDTH-1:0]     irq_en,
    input  logic [WIDTH-1:0]     pend_clr,
    input  logic [WIDTH-1:0]     cnt_clr,
    input  logic [IDX_W-1:0]     cnt_sel,
    output logic [WIDTH-1:0]     edge_pulse,
    output logic [WIDTH-1:0]     pending,
    output logic                 irq,
    output logic                 first_valid,
    output logic [IDX_W-1:0]     first_idx,
    output logic [CNT_WIDTH-1:0] cnt_out,
    output logic                 primed
);

    localparam int SET_W = $clog2(SYNC_STAGES + 1);

    logic [SET_W-1:0]     settle_q, settle_d;
    logic                 primed_q, primed_d;
    logic [CNT_WIDTH-1:0] cnt_w [WIDTH];

    // Hold off detection until the synchroniser and history flop carry real samples,
    // so a level already present at reset release is not mistaken for an edge.
    always_comb begin
        settle_d = settle_q;
        primed_d = primed_q;
        if (!primed_q) begin
            if (settle_q == SET_W'(SYNC_STAGES)) begin
                primed_d = 1'b1;
            end else begin
                settle_d = settle_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_q <= '0;
            primed_q <= 1'b0;
        end else begin
            settle_q <= settle_d;
            primed_q <= primed_d;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
        edge_event_chan #(
            .SYNC_STAGES(SYNC_STAGES),
            .CNT_WIDTH  (CNT_WIDTH)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .signal_i    (signal_in[g]),
            .mode_i      (mode[2*g +: 2]),
            .primed_i    (primed_q),
            .pend_clr_i  (pend_clr[g]),
            .cnt_clr_i   (cnt_clr[g]),
            .edge_pulse_o(edge_pulse[g]),
            .pending_o   (pending[g]),
            .cnt_o       (cnt_w[g])
        );
    end

    always_comb begin
        irq         = |(pending & irq_en);
        first_valid = |pending;
        first_idx   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                first_idx = IDX_W'(i);
            end
        end
        cnt_out = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (cnt_sel == IDX_W'(i)) begin
                cnt_out = cnt_w[i];
            end
        end
    end

    assign primed = primed_q;

endmodule

// File: tb/tb_edge_event_unit.sv
// Scoreboard bench for edge_event_unit: a per-edge reference model pushes expected state,
// a negedge monitor pops and compares every visible output.
module tb_edge_event_unit;

    localparam int W  = 4;
    localparam int S  = 2;
    localparam int CW = 2;
    localparam int IW = 2;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic [W-1:0]    pulse;
        logic [W-1:0]    pend;
        logic            primed;
        logic [W*CW-1:0] cnts;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [W-1:0]    signal_in;
    logic [2*W-1:0]  mode;
    logic [W-1:0]    irq_en;
    logic [W-1:0]    pend_clr;
    logic [W-1:0]    cnt_clr;
    logic [IW-1:0]   cnt_sel;
    logic [W-1:0]    edge_pulse;
    logic [W-1:0]    pending;
    logic            irq;
    logic            first_valid;
    logic [IW-1:0]   first_idx;
    logic [CW-1:0]   cnt_out;
    logic            primed;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t         exp_q[$];
    logic [W-1:0] samp_q[$];
    logic [W-1:0] m_pend;
    int           m_cnt [W];
    int           m_k;

    edge_event_unit #(.WIDTH(W), .SYNC_STAGES(S), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .signal_in  (signal_in),
        .mode       (mode),
        .irq_en     (irq_en),
        .pend_clr   (pend_clr),
        .cnt_clr    (cnt_clr),
        .cnt_sel    (cnt_sel),
        .edge_pulse (edge_pulse),
        .pending    (pending),
        .irq        (irq),
        .first_valid(first_valid),
        .first_idx  (first_idx),
        .cnt_out    (cnt_out),
        .primed     (primed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the pulse after edge k reflects the input transition between the samples
    // taken at edges k-S-1 and k-S, and detection only counts from edge S+2 after release.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_pend = '0;
            for (int i = 0; i < W; i++) m_cnt[i] = 0;
            m_k = 0;
            samp_q.delete();
            for (int i = 0; i <= S; i++) samp_q.push_back('0);
        end else begin
            logic [W-1:0] a, b;
            exp_t e;
            m_k++;
            a = samp_q[0];
            b = samp_q[1];
            e = '0;
            for (int i = 0; i < W; i++) begin
                bit rose, fell, ev;
                rose = !a[i] && b[i];
                fell = a[i] && !b[i];
                ev   = (m_k >= S + 2) && ((mode[2*i] && rose) || (mode[2*i+1] && fell));
                e.pulse[i] = ev;
                if (ev) m_pend[i] = 1'b1;
                else if (pend_clr[i]) m_pend[i] = 1'b0;
                if (cnt_clr[i]) m_cnt[i] = ev ? 1 : 0;
                else if (ev && m_cnt[i] < CMAX) m_cnt[i]++;
                e.cnts[i*CW +: CW] = CW'(m_cnt[i]);
            end
            e.pend   = m_pend;
            e.primed = (m_k >= S + 1);
            samp_q.push_back(signal_in);
            void'(samp_q.pop_front());
            exp_q.push_back(e);
        end
    end

    exp_t cur;
    always @(negedge clk) begin
        logic [IW-1:0] e_idx;
        if (!rst_n) begin
            exp_q.delete();
            cur = '0;
        end else if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
        end
        e_idx = '0;
        for (int i = W - 1; i >= 0; i--) if (cur.pend[i]) e_idx = IW'(i);
        chk("edge_pulse",  32'(edge_pulse),  32'(cur.pulse));
        chk("pending",     32'(pending),     32'(cur.pend));
        chk("primed",      32'(primed),      32'(cur.primed));
        chk("irq",         32'(irq),         32'(|(cur.pend & irq_en)));
        chk("first_valid", 32'(first_valid), 32'(|cur.pend));
        chk("first_idx",   32'(first_idx),   32'(e_idx));
        chk("cnt_out",     32'(cnt_out),     32'(cur.cnts[int'(cnt_sel)*CW +: CW]));
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rand_phase(input int n);
        for (int c = 0; c < n; c++) begin
            signal_in = W'($urandom);
            if (c % 16 == 0) mode = (2*W)'($urandom);
            if (c % 8 == 0) irq_en = W'($urandom);
            pend_clr = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
            cnt_clr  = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
            cnt_sel  = IW'($urandom);
            step();
        end
        pend_clr = '0;
        cnt_clr  = '0;
    endtask

    initial begin
        rst_n     = 1'b0;
        signal_in = 4'b1011;
        mode      = 8'hFF;
        irq_en    = 4'hF;
        pend_clr  = '0;
        cnt_clr   = '0;
        cnt_sel   = '0;

        // Levels high through reset must not produce events.
        step(3);
        rst_n = 1'b1;
        step(8);

        // Rising-only on ch0: a fall is ignored, a rise is counted once.
        mode = 8'b11_11_11_01;
        signal_in = 4'b1010;
        step(4);
        signal_in = 4'b1011;
        step(4);
        pend_clr = 4'hF;
        step();
        pend_clr = '0;

        // Priority encoder and IRQ masking.
        irq_en = '0;
        signal_in = 4'b1111;
        step(4);
        signal_in = 4'b1101;
        cnt_sel = 2'd1;
        step(4);
        irq_en = 4'b0100;
        pend_clr = 4'b0010;
        step();
        pend_clr = '0;
        step(2);

        // Saturation on ch3, then a clear coincident with an event.
        cnt_sel = 2'd3;
        for (int i = 0; i < 8; i++) begin
            signal_in[3] = ~signal_in[3];
            if (i == 6) cnt_clr = 4'b1000;
            else cnt_clr = '0;
            step();
        end
        cnt_clr = '0;
        step(4);

        // Clear coinciding with events on ch0 must lose to the set.
        cnt_sel = 2'd0;
        pend_clr = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            signal_in[0] = ~signal_in[0];
            step();
        end
        step(3);
        pend_clr = '0;
        step(2);

        rand_phase(400);

        // Asynchronous reset in the middle of a cycle.
        mode = 8'hFF;
        signal_in = 4'b0000;
        step(3);
        signal_in = 4'b1111;
        step(4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pulse",   32'(edge_pulse),  32'd0);
        chk("async_rst_pending", 32'(pending),     32'd0);
        chk("async_rst_irq",     32'(irq),         32'd0);
        chk("async_rst_fvalid",  32'(first_valid), 32'd0);
        chk("async_rst_fidx",    32'(first_idx),   32'd0);
        chk("async_rst_cnt",     32'(cnt_out),     32'd0);
        chk("async_rst_primed",  32'(primed),      32'd0);
        step(2);
        rst_n = 1'b1;
        step(8);

        rand_phase(150);
        step(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
